// File: rtl/coarse_cfo_rotator.sv
// coarse_cfo_rotator: removes a coarse carrier-frequency offset from symbol-rate I/Q samples.
// Each accepted sample k is multiplied by exp(-j*theta_k). theta_k comes from an NCO phase accumulator
// that advances by the loaded frequency word once per sample. The pipeline has four register stages:
//   capture -> table read -> multiply -> round/saturate.
// Build option: define COARSE_ROT_DITHER_EN to add an LFSR dither to the phase bits below the table index.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// UNLOADED  | no estimate yet; freq_reg = 0, samples pass through at phase 0
// ROTATING  | frequency word loaded; phase advances per sample, locked = 1

module coarse_cfo_rotator #(
  parameter int PHASE_ACC_BITS = 32,
  parameter int IQ_WIDTH       = 16,
  parameter int LUT_ADDR_BITS  = 10
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic signed [PHASE_ACC_BITS-1:0] freq_word,
  input  logic                             freq_load,
  input  logic                             clear,
  input  logic                             vld_in,
  input  logic signed [IQ_WIDTH-1:0]       i_in,
  input  logic signed [IQ_WIDTH-1:0]       q_in,
  output logic                             vld_out,
  output logic signed [IQ_WIDTH-1:0]       i_out,
  output logic signed [IQ_WIDTH-1:0]       q_out,
  output logic [PHASE_ACC_BITS-1:0]        phase_out,
  output logic                             locked
);

  localparam int LUT_SIZE = 1 << LUT_ADDR_BITS;
  localparam int MAX_POS  = (1 << (IQ_WIDTH-1)) - 1;
  localparam real TWO_PI  = 6.283185307179586;

  localparam logic signed [2*IQ_WIDTH:0] ROUND_C =
    {{(IQ_WIDTH+2){1'b0}}, 1'b1, {(IQ_WIDTH-2){1'b0}}};
  localparam logic signed [2*IQ_WIDTH:0] SAT_HI = {{(IQ_WIDTH+2){1'b0}}, {(IQ_WIDTH-1){1'b1}}};
  localparam logic signed [2*IQ_WIDTH:0] SAT_LO = {{(IQ_WIDTH+2){1'b1}}, {(IQ_WIDTH-1){1'b0}}};

  typedef enum logic {UNLOADED, ROTATING} state_t;

  // Scales a real value in [-1, 1] to Q1.(IQ_WIDTH-1). The value +1.0 clamps to the largest positive code.
  function automatic int to_q(input real x);
    int v;
    v = int'(x * (2.0 ** (IQ_WIDTH-1)));
    if (v > MAX_POS) v = MAX_POS;
    if (v < -MAX_POS-1) v = -MAX_POS-1;
    return v;
  endfunction

  // Adds half an LSB, drops the fraction bits, and clamps to the output range.
  function automatic logic signed [IQ_WIDTH-1:0] rnd_sat(input logic signed [2*IQ_WIDTH:0] s);
    logic signed [2*IQ_WIDTH:0] sh;
    sh = (s + ROUND_C) >>> (IQ_WIDTH-1);
    if (sh > SAT_HI)      rnd_sat = SAT_HI[IQ_WIDTH-1:0];
    else if (sh < SAT_LO) rnd_sat = SAT_LO[IQ_WIDTH-1:0];
    else                  rnd_sat = sh[IQ_WIDTH-1:0];
  endfunction

  state_t                    state;
  logic [PHASE_ACC_BITS-1:0] freq_reg;
  logic [PHASE_ACC_BITS-1:0] phase_acc;
  logic [PHASE_ACC_BITS-1:0] step_f;
  logic [LUT_ADDR_BITS-1:0]  lut_idx;

  logic signed [IQ_WIDTH-1:0] cos_tab [LUT_SIZE];
  logic signed [IQ_WIDTH-1:0] sin_tab [LUT_SIZE];

  // Constant cos/sin table. Entries are computed at elaboration, so it synthesizes as a ROM.
  for (genvar g = 0; g < LUT_SIZE; g++) begin : g_lut
    localparam int COS_V = to_q($cos(TWO_PI * real'(g) / real'(LUT_SIZE)));
    localparam int SIN_V = to_q($sin(TWO_PI * real'(g) / real'(LUT_SIZE)));
    assign cos_tab[g] = $signed(IQ_WIDTH'(COS_V));
    assign sin_tab[g] = $signed(IQ_WIDTH'(SIN_V));
  end

  // A word loaded in the same cycle as a sample already sets that sample's phase step.
  assign step_f = freq_load ? freq_word : ((state == ROTATING) ? freq_reg : '0);

`ifdef COARSE_ROT_DITHER_EN
  localparam int FRAC_BITS = PHASE_ACC_BITS - LUT_ADDR_BITS;
  logic [15:0]               lfsr;
  logic [PHASE_ACC_BITS-1:0] dither_vec;
  logic [PHASE_ACC_BITS-1:0] phase_dith;

  // Dither LFSR (x^16+x^14+x^13+x^11+1); it steps once for each accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      lfsr <= 16'hACE1;
    else if (vld_in) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  if (FRAC_BITS >= 16) begin : g_dith_wide
    assign dither_vec = {{(PHASE_ACC_BITS-16){1'b0}}, lfsr} << (FRAC_BITS-16);
  end else begin : g_dith_narrow
    assign dither_vec = PHASE_ACC_BITS'(lfsr >> (16-FRAC_BITS));
  end

  // Dither affects only the table index; phase_acc and phase_out stay clean.
  assign phase_dith = phase_acc + dither_vec;
  assign lut_idx    = phase_dith[PHASE_ACC_BITS-1 -: LUT_ADDR_BITS];
`else
  assign lut_idx = phase_acc[PHASE_ACC_BITS-1 -: LUT_ADDR_BITS];
`endif

  // Control FSM plus NCO. When clear and freq_load arrive together, clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= UNLOADED;
      freq_reg  <= '0;
      phase_acc <= '0;
      locked    <= 1'b0;
    end else if (clear) begin
      state     <= UNLOADED;
      freq_reg  <= '0;
      phase_acc <= '0;
      locked    <= 1'b0;
    end else begin
      if (vld_in) phase_acc <= phase_acc + step_f;
      if (freq_load) begin
        freq_reg <= freq_word;
        state    <= ROTATING;
        locked   <= 1'b1;
      end
    end
  end

  logic                       s1_vld, s2_vld, s3_vld;
  logic signed [IQ_WIDTH-1:0] s1_i, s1_q, s2_i, s2_q, s2_cos, s2_sin;
  logic [LUT_ADDR_BITS-1:0]   s1_idx;
  logic [PHASE_ACC_BITS-1:0]  s1_phase, s2_phase, s3_phase;
  logic signed [2*IQ_WIDTH-1:0] s3_ic, s3_qs, s3_qc, s3_is;
  logic signed [2*IQ_WIDTH:0]   sum_i, sum_q;

  // Stage 1: capture the sample together with the phase it will be rotated by.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_i     <= '0;
      s1_q     <= '0;
      s1_idx   <= '0;
      s1_phase <= '0;
    end else begin
      s1_vld <= vld_in;
      if (vld_in) begin
        s1_i     <= i_in;
        s1_q     <= q_in;
        s1_idx   <= lut_idx;
        s1_phase <= phase_acc;
      end
    end
  end

  // Stage 2: cos/sin table lookup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld   <= 1'b0;
      s2_i     <= '0;
      s2_q     <= '0;
      s2_cos   <= '0;
      s2_sin   <= '0;
      s2_phase <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_i     <= s1_i;
        s2_q     <= s1_q;
        s2_cos   <= cos_tab[s1_idx];
        s2_sin   <= sin_tab[s1_idx];
        s2_phase <= s1_phase;
      end
    end
  end

  // Stage 3: the four partial products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_vld   <= 1'b0;
      s3_ic    <= '0;
      s3_qs    <= '0;
      s3_qc    <= '0;
      s3_is    <= '0;
      s3_phase <= '0;
    end else begin
      s3_vld <= s2_vld;
      if (s2_vld) begin
        s3_ic    <= s2_i * s2_cos;
        s3_qs    <= s2_q * s2_sin;
        s3_qc    <= s2_q * s2_cos;
        s3_is    <= s2_i * s2_sin;
        s3_phase <= s2_phase;
      end
    end
  end

  // Full-precision sums for the exp(-j*theta) rotation.
  always_comb begin
    sum_i = $signed({s3_ic[2*IQ_WIDTH-1], s3_ic}) + $signed({s3_qs[2*IQ_WIDTH-1], s3_qs});
    sum_q = $signed({s3_qc[2*IQ_WIDTH-1], s3_qc}) - $signed({s3_is[2*IQ_WIDTH-1], s3_is});
  end

  // Stage 4: round, saturate and register the outputs. Outputs hold their values between valid samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_out   <= 1'b0;
      i_out     <= '0;
      q_out     <= '0;
      phase_out <= '0;
    end else begin
      vld_out <= s3_vld;
      if (s3_vld) begin
        i_out     <= rnd_sat(sum_i);
        q_out     <= rnd_sat(sum_q);
        phase_out <= s3_phase;
      end
    end
  end

endmodule
